// File: rtl/burst_stream_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// burst_stream_pkg : framing constants and host FSM states shared by both ends
// Revision 1.0
// ---------------------------------------------------------------------------
package burst_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_RECV = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  localparam int BSP_DATA_W  = 16;
  localparam int BSP_TIMEOUT = 64;
  // Receivers detect end-of-burst on the tx_valid falling edge, so bursts are
  // always separated by at least this many low cycles.
  localparam int MIN_GAP     = 1;

endpackage
`default_nettype wire

// File: rtl/stream_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_regfile : DEPTH x DATA_W array, one synchronous write, one async read
// Revision 1.0
// ---------------------------------------------------------------------------
module stream_regfile #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/burst_stream_host.sv
`default_nettype none
// ---------------------------------------------------------------------------
// burst_stream_host : sends a preloaded TX burst, captures the rx_valid reply.
// Optional echo checker enabled by BURST_STREAM_HOST_CHECK_EN. Revision 1.0
// ---------------------------------------------------------------------------
module burst_stream_host
  import burst_stream_pkg::*;
#(
  parameter int DATA_W  = BSP_DATA_W,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = BSP_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              start,
  input  logic [ADDR_W:0]   burst_len,
  output logic              busy,
  output logic              done,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   rx_count,
`ifdef BURST_STREAM_HOST_CHECK_EN
  output logic [ADDR_W:0]   mismatch_cnt,
`endif
  output logic              timeout_err,
  output logic              overflow_err
);

  localparam int              WAIT_W  = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W:0]   rx_count_q, rx_count_d;
  logic              timeout_err_q, timeout_err_d;
  logic              overflow_err_q, overflow_err_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;

  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W-1:0] tx_raddr;
  logic [DATA_W-1:0] tx_rdata;
  logic              rx_we;
  logic [ADDR_W-1:0] rx_waddr;

  assign len_clamped = (burst_len > DEPTH_C) ? DEPTH_C : burst_len;

  stream_regfile #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_txbuf (
    .clk   (clk),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (tx_raddr),
    .rdata (tx_rdata)
  );

  stream_regfile #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rxbuf (
    .clk   (clk),
    .we    (rx_we),
    .waddr (rx_waddr),
    .wdata (rx_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    idx_d          = idx_q;
    wait_d         = wait_q;
    rx_count_d     = rx_count_q;
    timeout_err_d  = timeout_err_q;
    overflow_err_d = overflow_err_q;
    tx_valid_d     = 1'b0;
    tx_data_d      = '0;
    rx_we          = 1'b0;
    rx_waddr       = rx_count_q[ADDR_W-1:0];
    tx_raddr       = idx_q[ADDR_W-1:0];

    case (state_q)
      ST_IDLE: begin
        tx_raddr = '0;
        if (start) begin
          len_d          = len_clamped;
          rx_count_d     = '0;
          timeout_err_d  = 1'b0;
          overflow_err_d = 1'b0;
          if (len_clamped == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d    = ST_SEND;
            tx_valid_d = 1'b1;
            tx_data_d  = tx_rdata;
            idx_d      = ONE_C;
          end
        end
      end
      ST_SEND: begin
        if (idx_q < len_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = tx_rdata;
          idx_d      = idx_q + ONE_C;
        end else begin
          state_d = ST_WAIT;
          wait_d  = '0;
        end
      end
      ST_WAIT: begin
        // TX port is idle after SEND; it follows the capture index for the checker.
        rx_waddr = '0;
        tx_raddr = '0;
        if (rx_valid) begin
          rx_we      = 1'b1;
          rx_count_d = ONE_C;
          state_d    = ST_RECV;
        end else if (wait_q == WAIT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = ST_FIN;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      ST_RECV: begin
        tx_raddr = rx_count_q[ADDR_W-1:0];
        if (rx_valid) begin
          if (rx_count_q < DEPTH_C) begin
            rx_we      = 1'b1;
            rx_count_d = rx_count_q + ONE_C;
          end else begin
            overflow_err_d = 1'b1;
          end
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      idx_q          <= '0;
      wait_q         <= '0;
      rx_count_q     <= '0;
      timeout_err_q  <= 1'b0;
      overflow_err_q <= 1'b0;
      tx_valid_q     <= 1'b0;
      tx_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      idx_q          <= idx_d;
      wait_q         <= wait_d;
      rx_count_q     <= rx_count_d;
      timeout_err_q  <= timeout_err_d;
      overflow_err_q <= overflow_err_d;
      tx_valid_q     <= tx_valid_d;
      tx_data_q      <= tx_data_d;
    end
  end

`ifdef BURST_STREAM_HOST_CHECK_EN
  logic [ADDR_W:0] mismatch_cnt_q, mismatch_cnt_d;

  always_comb begin
    mismatch_cnt_d = mismatch_cnt_q;
    if (state_q == ST_IDLE && start) begin
      mismatch_cnt_d = '0;
    end else if (rx_we && (rx_data != tx_rdata)) begin
      mismatch_cnt_d = mismatch_cnt_q + ONE_C;
    end else if (state_q == ST_FIN && rx_count_q != len_q) begin
      mismatch_cnt_d = mismatch_cnt_q + ONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch_cnt_q <= '0;
    end else begin
      mismatch_cnt_q <= mismatch_cnt_d;
    end
  end

  assign mismatch_cnt = mismatch_cnt_q;
`endif

  assign busy         = (state_q == ST_SEND) || (state_q == ST_WAIT) || (state_q == ST_RECV);
  assign done         = (state_q == ST_FIN);
  assign tx_valid     = tx_valid_q;
  assign tx_data      = tx_data_q;
  assign rx_count     = rx_count_q;
  assign timeout_err  = timeout_err_q;
  assign overflow_err = overflow_err_q;

endmodule
`default_nettype wire

// File: tb/tb_burst_stream_host.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_burst_stream_host : directed bench for burst_stream_host
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_burst_stream_host;

  localparam int DATA_W  = 16;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [DATA_W-1:0] cfg_wdata = '0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   burst_len = '0;
  logic              busy, done, tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              rx_valid = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   rx_count;
  logic              timeout_err, overflow_err;
`ifdef BURST_STREAM_HOST_CHECK_EN
  logic [ADDR_W:0]   mismatch_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] txm [DEPTH];

  burst_stream_host #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .start        (start),
    .burst_len    (burst_len),
    .busy         (busy),
    .done         (done),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rx_count     (rx_count),
`ifdef BURST_STREAM_HOST_CHECK_EN
    .mismatch_cnt (mismatch_cnt),
`endif
    .timeout_err  (timeout_err),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rd(input string tag, input int addr, input logic [DATA_W-1:0] exp);
    rd_addr = ADDR_W'(addr);
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    int n;
    // reset state
    step(); step();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_txv", 32'(tx_valid), 0);
    check("rst_txd", 32'(tx_data), 0);
    check("rst_cnt", 32'(rx_count), 0);
    check("rst_errs", {30'd0, timeout_err, overflow_err}, 0);
    rst_n = 1'b1;

    // preload TX buffer
    for (int i = 0; i < DEPTH; i++) begin
      txm[i] = (i < 3) ? DATA_W'(16'h1111 * (i + 1)) : DATA_W'(16'hA000 + i);
      cfg_we = 1'b1; cfg_addr = ADDR_W'(i); cfg_wdata = txm[i];
      step();
    end
    cfg_we = 1'b0;

    // 3-word burst, echoed after 2 idle cycles
    start = 1'b1; burst_len = 5'd3;
    step();
    start = 1'b0;
    check("t1_busy", 32'(busy), 1);
    check("t1_w0", {15'd0, tx_valid, tx_data}, {16'd1, 16'h1111});
    step();
    check("t1_w1", {15'd0, tx_valid, tx_data}, {16'd1, 16'h2222});
    step();
    check("t1_w2", {15'd0, tx_valid, tx_data}, {16'd1, 16'h3333});
    step();
    check("t1_txend", {15'd0, tx_valid, tx_data}, 0);
    step(); step();
    rx_valid = 1'b1; rx_data = 16'h1111; step();
    rx_data = 16'h2222; step();
    rx_data = 16'h3333; step();
    rx_valid = 1'b0;
    check("t1_cnt", 32'(rx_count), 3);
    check("t1_nodone", 32'(done), 0);
    step();
    check("t1_done", {30'd0, done, busy}, 32'b10);
    step();
    check("t1_after", {30'd0, done, busy}, 0);
    check_rd("t1_rx0", 0, 16'h1111);
    check_rd("t1_rx1", 1, 16'h2222);
    check_rd("t1_rx2", 2, 16'h3333);
`ifdef BURST_STREAM_HOST_CHECK_EN
    check("t1_mis", 32'(mismatch_cnt), 0);
`endif

    // timeout: one word, no response
    start = 1'b1; burst_len = 5'd1;
    step();
    start = 1'b0;
    check("t2_w0", 32'(tx_valid), 1);
    step();
    check("t2_txfall", 32'(tx_valid), 0);
    for (int k = 1; k < TIMEOUT; k++) step();
    check("t2_pre", {30'd0, timeout_err, done}, 0);
    step();
    check("t2_tout", {30'd0, timeout_err, done}, 32'b11);
    check("t2_cnt", 32'(rx_count), 0);
    step();
    check("t2_sticky", {30'd0, timeout_err, done}, 32'b10);

    // overflow: 20 words returned for a 2-word burst
    start = 1'b1; burst_len = 5'd2;
    step();
    start = 1'b0;
    check("t3_timeout_clr", 32'(timeout_err), 0);
    step(); step();
    rx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx_data = DATA_W'(16'hC000 + i);
      step();
    end
    rx_valid = 1'b0;
    check("t3_cnt", 32'(rx_count), 16);
    check("t3_ovf", 32'(overflow_err), 1);
    step();
    check("t3_done", 32'(done), 1);
    step();
    for (int i = 0; i < DEPTH; i++) check_rd("t3_rx", i, DATA_W'(16'hC000 + i));
`ifdef BURST_STREAM_HOST_CHECK_EN
    check("t3_mis", 32'(mismatch_cnt), 17);
`endif

    // zero-length transaction
    start = 1'b1; burst_len = 5'd0;
    step();
    start = 1'b0;
    check("t4_done", {29'd0, done, tx_valid, busy}, 32'b100);
    check("t4_ovf_clr", 32'(overflow_err), 0);
    step();
    check("t4_after", 32'(done), 0);

    // burst_len 31 clamps to DEPTH words
    start = 1'b1; burst_len = 5'd31;
    step();
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (tx_valid) begin
        if (n < DEPTH) check("t5_word", 32'(tx_data), 32'(txm[n]));
        n++;
      end
      step();
    end
    check("t5_len", n, DEPTH);
    for (int k = 0; k < 100 && !done; k++) step();
    check("t5_done", {30'd0, done, timeout_err}, 32'b11);
    step();

    // reset on the 2nd SEND cycle, then a fresh transaction
    start = 1'b1; burst_len = 5'd4;
    step();
    start = 1'b0;
    step();
    check("t6_send2", 32'(tx_valid), 1);
    rst_n = 1'b0;
    step();
    check("t6_rst", {29'd0, tx_valid, busy, done}, 0);
    rst_n = 1'b1;
    step();
    check("t6_nodone", 32'(done), 0);
    start = 1'b1; burst_len = 5'd2;
    step();
    start = 1'b0;
    check("t6_w0", 32'(tx_data), 32'h1111);
    step(); step();
    rx_valid = 1'b1; rx_data = 16'h5A5A; step();
    rx_data = 16'hA5A5; step();
    rx_valid = 1'b0;
    check("t6_cnt", 32'(rx_count), 2);
    step();
    check("t6_done", 32'(done), 1);
    check_rd("t6_rx0", 0, 16'h5A5A);
    check_rd("t6_rx1", 1, 16'hA5A5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/burst_stream_host.md
Name: burst_stream_host

Overview:
- Transmitter/collector at the far end of the 16-bit valid-framed burst interface.
- Streams a preloaded buffer as one contiguous tx_valid burst; the burst length is implied by tx_valid deasserting.
- Then waits for the responder's rx_valid burst and captures it into a readable receive buffer.
- Used as a bring-up/test host for the memory-backed core and any block speaking the same framing.

Parameters:
- DATA_W, 16, word width of tx/rx data.
- DEPTH, 16, entries in each of the TX and RX buffers (power of 2).
- ADDR_W, 4, log2(DEPTH).
- TIMEOUT, 64, maximum idle cycles allowed between the end of TX and the first rx_valid.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- cfg_we  in  1  write enable for the TX buffer.
- cfg_addr  in  ADDR_W  TX buffer write address.
- cfg_wdata  in  DATA_W  TX buffer write data.
- start  in  1  one-cycle request to run a transaction.
- burst_len  in  ADDR_W+1  number of words to send, sampled with start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- tx_valid  out  1  burst framing to the responder.
- tx_data  out  DATA_W  burst data.
- rx_valid  in  1  response framing from the responder.
- rx_data  in  DATA_W  response data.
- rd_addr  in  ADDR_W  RX buffer read address.
- rd_data  out  DATA_W  RX buffer read data, combinational from rd_addr.
- rx_count  out  ADDR_W+1  words captured in the last transaction.
- timeout_err  out  1  sticky until next start; no response arrived within TIMEOUT.
- overflow_err  out  1  sticky until next start; response exceeded DEPTH words.

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk.
  - Outputs at reset: busy=0, done=0, tx_valid=0, tx_data=0, rx_count=0, timeout_err=0, overflow_err=0; FSM in IDLE.
  - Buffer contents are not reset.
  - Reset asserted mid-transaction drops tx_valid at the next edge and discards the transaction; no done pulse.
- FSM states: IDLE, SEND, WAIT, RECV, FIN.
- IDLE:
  - On start, latch len = min(burst_len, DEPTH), clear rx_count and both error flags, assert busy.
  - len == 0 goes directly to FIN.
  - Otherwise go to SEND. tx_valid=1 and tx_data=txbuf[0] appear at the edge after start (1-cycle latency).
  - start while busy is ignored.
- SEND:
  - tx_valid held high for exactly len consecutive cycles, words txbuf[0..len-1] in order, no gaps.
  - tx_data returns to 0 when tx_valid is low.
  - After the last word, tx_valid=0 and the FSM moves to WAIT with the wait counter cleared.
- WAIT:
  - rx_valid=1 moves to RECV and captures that word into rxbuf[0]; rx_count becomes 1.
  - If TIMEOUT cycles elapse without rx_valid: set timeout_err, go to FIN.
  - rx_valid seen during SEND is ignored.
- RECV:
  - Each rx_valid=1 cycle writes rxbuf[rx_count] and increments rx_count.
  - Words beyond DEPTH are dropped, overflow_err is set, and rx_count saturates at DEPTH.
  - The first rx_valid=0 cycle ends the response and moves to FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE. A new start is accepted the cycle after done.
- Gap guarantee: at least 1 low cycle between consecutive tx_valid bursts; the receiver relies on the falling edge.
- cfg_we during busy: the write is allowed, but it takes effect only for later transactions if the address has already been sent. The integrator's responsibility; no error is flagged.
- rd_data is valid at any time; reading during RECV returns old or new data per address.

Optional Feature:
- Macro: BURST_STREAM_HOST_CHECK_EN.
- Defined:
  - Extra output mismatch_cnt (ADDR_W+1 bits), cleared on start.
  - Incremented for each captured word i where rxbuf[i] != txbuf[i].
  - Also incremented once at FIN if rx_count != len (echo expectation).
- Undefined: the port and comparison logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (burst_stream_pkg): FSM state enum, DATA_W default, and the framing constants MIN_GAP=1 and TIMEOUT default, so the core-side and host-side blocks agree.
- One natural sub-module: stream_regfile, a DEPTH x DATA_W, 1-write, 1-async-read array, instantiated twice (TX, RX).

Test Plan:
- Load txbuf[0..2]=0x1111,0x2222,0x3333; start with burst_len=3 → tx_valid high 3 cycles starting the edge after start with 0x1111,0x2222,0x3333, then low.
- Echo responder returns 3 words after 2 idle cycles → rx_count=3, rxbuf matches, done pulses once, busy low next cycle; with CHECK_EN, mismatch_cnt=0.
- No responder activity → timeout_err=1 exactly TIMEOUT cycles after the last tx word; done pulse; rx_count=0.
- Responder returns 20 words with DEPTH=16 → rx_count=16, overflow_err=1, rxbuf holds the first 16 words.
- burst_len=0 → no tx_valid, done the cycle after IDLE→FIN; burst_len=31 clamps to 16 words sent.
- rst_n low on the 2nd SEND cycle → tx_valid=0 at the next edge, busy=0, no done; a fresh start afterwards completes normally.
